// File: rtl/rotor1_reverse.sv
// Reflector-side inverse of rotor 1 plus the rotor-1 position register.
// Latency: 2 cycles from acceptance to out_valid; throughput 1 letter/cycle.
// Backpressure: stage 2 holds while out_valid&!out_ready; in_ready is combinational from out_ready.
module rotor1_reverse #(
    parameter int NPOS  = 26,
    parameter int NOTCH = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out,
    output logic       err,
    input  logic       load_en,
    input  logic [4:0] load_pos,
    input  logic       step,
    output logic [4:0] rotate,
    output logic       carry
);

    localparam logic [4:0] MAX_POS  = 5'(NPOS - 1);
    localparam logic [4:0] WRAP_POS = 5'(NOTCH);
    localparam logic [5:0] NPOS6    = 6'(NPOS);

    logic [4:0] rotate_q, rotate_d;
    logic       carry_q, carry_d;
    logic       rdy_en_q;
    logic       s1_vld_q, s1_vld_d, s1_err_q;
    logic [4:0] s1_m_q, s1_m_d;
    logic       s2_vld_q, s2_vld_d, s2_err_q;
    logic [4:0] s2_out_q;
    logic       acc, s1_adv, in_err;
    logic [4:0] r, m5;
    logic [5:0] m6;

    function automatic logic [4:0] inv_map(input logic [4:0] m);
        case (m)
            5'd1:  inv_map = 5'd15;  5'd2:  inv_map = 5'd24;  5'd3:  inv_map = 5'd8;
            5'd4:  inv_map = 5'd4;   5'd5:  inv_map = 5'd23;  5'd6:  inv_map = 5'd17;
            5'd7:  inv_map = 5'd6;   5'd8:  inv_map = 5'd9;   5'd9:  inv_map = 5'd20;
            5'd10: inv_map = 5'd21;  5'd11: inv_map = 5'd12;  5'd12: inv_map = 5'd26;
            5'd13: inv_map = 5'd3;   5'd14: inv_map = 5'd7;   5'd15: inv_map = 5'd16;
            5'd16: inv_map = 5'd1;   5'd17: inv_map = 5'd5;   5'd18: inv_map = 5'd14;
            5'd19: inv_map = 5'd10;  5'd20: inv_map = 5'd22;  5'd21: inv_map = 5'd19;
            5'd22: inv_map = 5'd11;  5'd23: inv_map = 5'd13;  5'd24: inv_map = 5'd18;
            5'd25: inv_map = 5'd2;   5'd26: inv_map = 5'd25;
            default: inv_map = 5'd0;
        endcase
    endfunction

    // Handshake: stage 1 moves on when stage 2 is empty or draining this cycle.
    always_comb begin
        s1_adv   = s1_vld_q & (~s2_vld_q | out_ready);
        in_ready = rdy_en_q & (~s1_vld_q | ~s2_vld_q | out_ready);
        acc      = in_valid & in_ready;
        s1_vld_d = acc | (s1_vld_q & ~s1_adv);
        s2_vld_d = s1_adv | (s2_vld_q & ~out_ready);
    end

    // Subtract the rotation captured at acceptance; letter 0 of the ring is contact 26.
    always_comb begin
        in_err = (in > 5'd26);
        r      = (in == 5'd26) ? 5'd0 : in;
        m6     = {1'b0, r} + NPOS6 - {1'b0, rotate_q};
        m5     = (m6 >= NPOS6) ? 5'(m6 - NPOS6) : m6[4:0];
        s1_m_d = in_err ? 5'd0 : ((m5 == 5'd0) ? 5'd26 : m5);
    end

    // A load with an out-of-range position swallows any same-cycle step.
    always_comb begin
        rotate_d = rotate_q;
        carry_d  = 1'b0;
        if (load_en) begin
            if (load_pos <= MAX_POS) rotate_d = load_pos;
        end else if (step) begin
            if (rotate_q == WRAP_POS) begin
                rotate_d = 5'd0;
                carry_d  = 1'b1;
            end else begin
                rotate_d = rotate_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rotate_q <= 5'd0;
            carry_q  <= 1'b0;
            rdy_en_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_m_q   <= 5'd0;
            s2_vld_q <= 1'b0;
            s2_err_q <= 1'b0;
            s2_out_q <= 5'd0;
        end else begin
            rotate_q <= rotate_d;
            carry_q  <= carry_d;
            rdy_en_q <= 1'b1;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            if (acc) begin
                s1_m_q   <= s1_m_d;
                s1_err_q <= in_err;
            end
            if (s1_adv) begin
                s2_out_q <= s1_err_q ? 5'd0 : inv_map(s1_m_q);
                s2_err_q <= s1_err_q;
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign out       = s2_out_q;
    assign err       = s2_err_q;
    assign rotate    = rotate_q;
    assign carry     = carry_q;

endmodule
